// File: rtl/wb_port_arbiter.sv
// Round-robin write-port arbiter: three requesters share one register-file
// write port, with a one-cycle registered write and a hold input that blocks grants.
module wb_port_arbiter #(
    parameter int          DATA_W   = 64,
    parameter logic [3:0]  ZERO_REG = 4'hF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        req_valid,
    input  logic [3:0]        req_addr0,
    input  logic [3:0]        req_addr1,
    input  logic [3:0]        req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    input  logic              hold,
    output logic [15:0]       wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_src,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_HELD   = 2'b10
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [1:0]          rr_ptr_q;
    logic [1:0]          rr_ptr_d;
    logic [15:0]         wr_en_q;
    logic [15:0]         wr_en_d;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   wr_data_d;
    logic [1:0]          wr_src_q;
    logic [1:0]          wr_src_d;

    logic                win_found;
    logic [1:0]          win_idx;
    logic                any_valid;
    logic                xfer;
    logic [3:0]          sel_addr;
    logic [DATA_W-1:0]   sel_data;

    assign any_valid = |req_valid;

    // Round-robin search starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        unique case (rr_ptr_q)
            2'd1: begin
                if (req_valid[1]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd1;
                end else if (req_valid[2]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd2;
                end else if (req_valid[0]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd0;
                end
            end
            2'd2: begin
                if (req_valid[2]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd2;
                end else if (req_valid[0]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd0;
                end else if (req_valid[1]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd1;
                end
            end
            default: begin
                if (req_valid[0]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd0;
                end else if (req_valid[1]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd1;
                end else if (req_valid[2]) begin
                    win_found = 1'b1;
                    win_idx   = 2'd2;
                end
            end
        endcase
    end

    // Grant only the winner; reset and hold both block every grant.
    always_comb begin
        xfer      = reset_n & ~hold & win_found;
        req_ready = 3'b000;
        if (xfer) begin
            req_ready = 3'b001 << win_idx;
        end
    end

    // Route the winner's destination and data toward the capture flops.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        unique case (win_idx)
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            2'd2: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    // Next write-port contents and pointer; wr_en pulses one cycle per transfer.
    always_comb begin
        wr_en_d   = 16'h0000;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            wr_data_d = sel_data;
            wr_src_d  = win_idx;
            rr_ptr_d  = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            if (sel_addr != ZERO_REG) begin
                wr_en_d = 16'h0001 << sel_addr;
            end
        end
    end

    // FSM next state from the current request and hold inputs.
    always_comb begin
        state_d = ST_IDLE;
        if (any_valid) begin
            state_d = hold ? ST_HELD : ST_ACTIVE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-port and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en_q   <= 16'h0000;
            wr_data_q <= '0;
            wr_src_q  <= 2'd0;
            rr_ptr_q  <= 2'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;
    assign state   = state_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus a sweep
// of all destination addresses through a single requester.
module tb_wb_port_arbiter;

    localparam int DW = 64;

    logic          clk;
    logic          reset_n;
    logic [2:0]    req_valid;
    logic [3:0]    req_addr0, req_addr1, req_addr2;
    logic [DW-1:0] req_data0, req_data1, req_data2;
    logic [2:0]    req_ready;
    logic          hold;
    logic [15:0]   wr_en;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_src;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.DATA_W(DW), .ZERO_REG(4'hF)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .req_ready(req_ready), .hold(hold), .wr_en(wr_en),
        .wr_data(wr_data), .wr_src(wr_src), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        hld;
        logic [2:0]  vld;
        logic [3:0]  a0, a1, a2;
        logic [2:0]  rdy;
        logic [15:0] we;
        logic [63:0] wd;
        logic [1:0]  ws;
        logic [1:0]  st;
    } vec_t;

    vec_t vq[$];

    localparam logic [63:0] D0 = 64'hAA;
    localparam logic [63:0] D1 = 64'hB1;
    localparam logic [63:0] D2 = 64'hC2;

    function automatic void add(input logic r, input logic h,
                                input logic [2:0] v,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [2:0] rdy,
                                input logic [15:0] we, input logic [63:0] wd,
                                input logic [1:0] ws, input logic [1:0] st);
        vec_t x;
        x.rst_n = r; x.hld = h; x.vld = v;
        x.a0 = a0; x.a1 = a1; x.a2 = a2;
        x.rdy = rdy; x.we = we; x.wd = wd; x.ws = ws; x.st = st;
        vq.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        hold      = 1'b0;
        req_valid = 3'b000;
        req_addr0 = 4'd0; req_addr1 = 4'd0; req_addr2 = 4'd0;
        req_data0 = D0;   req_data1 = D1;   req_data2 = D2;

        // reset with all requesting: no grant, everything cleared
        add(0, 0, 3'b111, 1, 6, 9, 3'b000, 16'h0000, 64'h0, 0, 2'b00);
        // basic write: addr 3 from ALU
        add(1, 0, 3'b001, 3, 6, 9, 3'b001, 16'h0008, D0, 0, 2'b01);
        // sole requester wins even though rr_ptr=1
        add(1, 0, 3'b001, 5, 6, 9, 3'b001, 16'h0020, D0, 0, 2'b01);
        add(1, 0, 3'b100, 5, 6, 2, 3'b100, 16'h0004, D2, 2, 2'b01);
        // all three continuously from rr_ptr=0
        add(1, 0, 3'b111, 1, 6, 9, 3'b001, 16'h0002, D0, 0, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b010, 16'h0040, D1, 1, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b100, 16'h0200, D2, 2, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b001, 16'h0002, D0, 0, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b010, 16'h0040, D1, 1, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b100, 16'h0200, D2, 2, 2'b01);
        // hold for three cycles
        add(1, 1, 3'b110, 1, 6, 9, 3'b000, 16'h0000, D2, 2, 2'b10);
        add(1, 1, 3'b110, 1, 6, 9, 3'b000, 16'h0000, D2, 2, 2'b10);
        add(1, 1, 3'b110, 1, 6, 9, 3'b000, 16'h0000, D2, 2, 2'b10);
        // hold released: requester 1 in the same cycle
        add(1, 0, 3'b110, 1, 6, 9, 3'b010, 16'h0040, D1, 1, 2'b01);
        // idle with hold high: hold ignored
        add(1, 1, 3'b000, 1, 6, 9, 3'b000, 16'h0000, D1, 1, 2'b00);
        // write to the zero register
        add(1, 0, 3'b100, 1, 6, 15, 3'b100, 16'h0000, D2, 2, 2'b01);
        // pointer wrapped to 0
        add(1, 0, 3'b111, 1, 6, 9, 3'b001, 16'h0002, D0, 0, 2'b01);
        add(1, 0, 3'b111, 1, 6, 9, 3'b010, 16'h0040, D1, 1, 2'b01);
        // reset mid-stream
        add(0, 0, 3'b111, 1, 6, 9, 3'b000, 16'h0000, 64'h0, 0, 2'b00);
        add(1, 0, 3'b111, 1, 6, 9, 3'b001, 16'h0002, D0, 0, 2'b01);
        // skip-over of the non-requester at rr_ptr=1
        add(1, 0, 3'b101, 1, 6, 9, 3'b100, 16'h0200, D2, 2, 2'b01);
        add(1, 0, 3'b101, 1, 6, 9, 3'b001, 16'h0002, D0, 0, 2'b01);
        // requests dropped: wr_en returns to 0, data holds
        add(1, 0, 3'b000, 1, 6, 9, 3'b000, 16'h0000, D0, 0, 2'b00);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset_n   = vq[i].rst_n;
            hold      = vq[i].hld;
            req_valid = vq[i].vld;
            req_addr0 = vq[i].a0;
            req_addr1 = vq[i].a1;
            req_addr2 = vq[i].a2;
            #1;
            chk("req_ready", i, 64'(req_ready), 64'(vq[i].rdy));
            @(posedge clk);
            #1;
            chk("wr_en", i, 64'(wr_en), 64'(vq[i].we));
            chk("wr_data", i, wr_data, vq[i].wd);
            chk("wr_src", i, 64'(wr_src), 64'(vq[i].ws));
            chk("state", i, 64'(state), 64'(vq[i].st));
        end

        // requester 1 walks every destination address back-to-back
        for (int a = 0; a < 16; a++) begin
            logic [15:0] exp_we;
            exp_we = (a == 15) ? 16'h0000 : (16'h0001 << a);
            @(negedge clk);
            reset_n   = 1'b1;
            hold      = 1'b0;
            req_valid = 3'b010;
            req_addr1 = 4'(a);
            req_data1 = 64'h1000 + 64'(a);
            #1;
            chk("sweep_ready", a, 64'(req_ready), 64'h2);
            @(posedge clk);
            #1;
            chk("sweep_wr_en", a, 64'(wr_en), 64'(exp_we));
            chk("sweep_wr_data", a, wr_data, 64'h1000 + 64'(a));
            chk("sweep_wr_src", a, 64'(wr_src), 64'd1);
        end

        // wr_en must drop right after the last transfer
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("tail_wr_en", 0, 64'(wr_en), 64'h0);
        chk("tail_wr_data", 0, wr_data, 64'h100F);
        chk("tail_state", 0, 64'(state), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
